// File: rtl/pong_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pong_pkg                                                          |
// | Shared types and colour constants for the pong game engine.       |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    MISS = 2'd2,
    OVER = 2'd3
  } state_e;

  typedef logic signed [3:0] vel_t;

  localparam int SPEED_MAX = 6;

  localparam logic [11:0] c_RGB_WALL    = 12'h00f;
  localparam logic [11:0] c_RGB_PADDLE  = 12'h0f0;
  localparam logic [11:0] c_RGB_BALL    = 12'hf00;
  localparam logic [11:0] c_RGB_BG      = 12'hfff;
  localparam logic [11:0] c_RGB_OVER_BG = 12'h400;

  function automatic logic [3:0] vel_mag(input vel_t v);
    return v[3] ? 4'(-v) : 4'(v);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pong_frame_tick.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pong_frame_tick                                                   |
// | Free-running divider with a registered one-cycle frame strobe.    |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module pong_frame_tick #(
  parameter int TICK_DIV = 1666667
) (
  input  logic clk,
  input  logic rst,
  output logic o_tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] c_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  // Strobe is high for the cycle after the count sits at its last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == c_LAST) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + CW'(1);
      r_tick <= 1'b0;
    end
  end

  assign o_tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/pong_game_engine.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pong_game_engine                                                  |
// | Frame-ticked ball/paddle physics, game FSM and pixel renderer.    |
// | Optional: define PONG_BALL_ACCEL_EN for speed-up every 4th hit.   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module pong_game_engine
  import pong_pkg::*;
#(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int TICK_DIV    = 1666667,
  parameter int WALL_X      = 32,
  parameter int WALL_W      = 4,
  parameter int PADDLE_X    = 600,
  parameter int PADDLE_W    = 4,
  parameter int PADDLE_H    = 72,
  parameter int PADDLE_STEP = 4,
  parameter int BALL_SIZE   = 8,
  parameter int BALL_SPEED  = 2,
  parameter int LIVES       = 3,
  parameter int MISS_FRAMES = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        video_on,
  input  logic [1:0]  btn,
  input  logic        start,
  output logic [11:0] RGB,
  output logic [7:0]  score,
  output logic [2:0]  lives,
  output logic        game_over,
  output logic        frame_tick
);

  localparam logic [10:0] c_WALL_L  = 11'(WALL_X);
  localparam logic [10:0] c_WALL_R  = 11'(WALL_X + WALL_W);
  localparam logic [10:0] c_PAD_L   = 11'(PADDLE_X);
  localparam logic [10:0] c_PAD_R   = 11'(PADDLE_X + PADDLE_W - 1);
  localparam logic [10:0] c_H       = 11'(H_RES);
  localparam logic [10:0] c_V       = 11'(V_RES);
  localparam logic [10:0] c_BS      = 11'(BALL_SIZE);
  localparam logic [10:0] c_PH      = 11'(PADDLE_H);
  localparam logic [10:0] c_PS      = 11'(PADDLE_STEP);
  localparam logic [9:0]  c_PAD_Y0  = 10'((V_RES - PADDLE_H) / 2);
  localparam logic [9:0]  c_SERVE_X = 10'(WALL_X + WALL_W);
  localparam logic [9:0]  c_SERVE_Y = 10'((V_RES - BALL_SIZE) / 2);
  localparam logic [9:0]  c_STEP    = 10'(PADDLE_STEP);
  localparam logic [3:0]  c_SPEED0  = 4'(BALL_SPEED);
  localparam logic [2:0]  c_LIVES   = 3'(LIVES);
  localparam int          MW        = $clog2(MISS_FRAMES + 1);
  localparam logic [MW-1:0] c_MISS_LAST = MW'(MISS_FRAMES - 1);

  state_e          r_state;
  logic [9:0]      r_ball_x;
  logic [9:0]      r_ball_y;
  logic [9:0]      r_paddle_y;
  vel_t            r_vx;
  vel_t            r_vy;
  logic [7:0]      r_score;
  logic [2:0]      r_lives;
  logic            r_game_over;
  logic [MW-1:0]   r_miss_cnt;

  logic            w_tick;
  logic [10:0]     w_bx, w_by, w_pad;
  logic [10:0]     w_right;
  logic [3:0]      w_mag_x, w_mag_y;
  logic            w_miss, w_top, w_bot, w_wall, w_hit;
  logic            w_vx_pos, w_vy_pos;
  logic [9:0]      w_ball_x_next, w_ball_y_next;
  logic [9:0]      w_paddle_next;
  logic [7:0]      w_score_inc;
  logic            w_step, w_serve_again, w_restart;
  logic [3:0]      w_speed_next;
  vel_t            w_vx_next, w_vy_next;

  pong_frame_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_frame_tick (
    .clk    (clk),
    .rst    (reset),
    .o_tick (w_tick)
  );

  assign frame_tick = w_tick;
  assign score      = r_score;
  assign lives      = r_lives;
  assign game_over  = r_game_over;

  assign w_bx    = {1'b0, r_ball_x};
  assign w_by    = {1'b0, r_ball_y};
  assign w_pad   = {1'b0, r_paddle_y};
  assign w_mag_x = vel_mag(r_vx);
  assign w_mag_y = vel_mag(r_vy);
  assign w_right = w_bx + c_BS;

  assign w_miss = w_right >= c_H;
  assign w_top  = w_by <= {7'd0, w_mag_y};
  assign w_bot  = (w_by + c_BS + {7'd0, w_mag_y}) >= c_V;
  assign w_wall = w_bx <= c_WALL_R;
  assign w_hit  = (w_right >= c_PAD_L) && (w_right <= c_PAD_R) &&
                  (w_by < w_pad + c_PH) && (w_by + c_BS > w_pad) && !r_vx[3];

  // Bounces are resolved from the current position; the move uses the old magnitude.
  assign w_vx_pos = w_hit ? 1'b0 : (w_wall | ~r_vx[3]);
  assign w_vy_pos = w_top ? 1'b1 : (w_bot ? 1'b0 : ~r_vy[3]);

  assign w_ball_x_next = w_vx_pos ? (r_ball_x + 10'(w_mag_x)) : (r_ball_x - 10'(w_mag_x));
  assign w_ball_y_next = w_vy_pos ? (r_ball_y + 10'(w_mag_y)) : (r_ball_y - 10'(w_mag_y));

  assign w_score_inc   = (r_score == 8'hff) ? r_score : (r_score + 8'd1);
  assign w_step        = (r_state == PLAY) && w_tick && !w_miss;
  assign w_serve_again = (r_state == MISS) && w_tick && (r_miss_cnt == c_MISS_LAST) &&
                         (r_lives != 3'd0);
  assign w_restart     = (r_state == OVER) && start;

`ifdef PONG_BALL_ACCEL_EN
  logic [3:0] r_speed;

  always_comb begin
    w_speed_next = r_speed;
    if (w_step && w_hit && (w_score_inc[1:0] == 2'b00) && (r_speed < 4'(SPEED_MAX)))
      w_speed_next = r_speed + 4'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_speed <= c_SPEED0;
    else if (w_serve_again || w_restart)
      r_speed <= c_SPEED0;
    else
      r_speed <= w_speed_next;
  end
`else
  assign w_speed_next = c_SPEED0;
`endif

  assign w_vx_next = w_vx_pos ? vel_t'(w_speed_next) : -vel_t'(w_speed_next);
  assign w_vy_next = w_vy_pos ? vel_t'(w_speed_next) : -vel_t'(w_speed_next);

  // Whole steps only: a move that would cross the screen edge is dropped.
  always_comb begin
    w_paddle_next = r_paddle_y;
    if ((btn == 2'b10) && ((w_pad + c_PH + c_PS) <= c_V))
      w_paddle_next = r_paddle_y + c_STEP;
    else if ((btn == 2'b01) && (w_pad >= c_PS))
      w_paddle_next = r_paddle_y - c_STEP;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_ball_x    <= c_SERVE_X;
      r_ball_y    <= c_SERVE_Y;
      r_paddle_y  <= c_PAD_Y0;
      r_vx        <= vel_t'(c_SPEED0);
      r_vy        <= vel_t'(c_SPEED0);
      r_score     <= 8'd0;
      r_lives     <= c_LIVES;
      r_game_over <= 1'b0;
      r_miss_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_tick)
            r_paddle_y <= w_paddle_next;
          if (start)
            r_state <= PLAY;
        end
        PLAY: begin
          if (w_tick) begin
            r_paddle_y <= w_paddle_next;
            if (w_miss) begin
              r_state    <= MISS;
              r_lives    <= r_lives - 3'd1;
              r_miss_cnt <= '0;
            end else begin
              r_ball_x <= w_ball_x_next;
              r_ball_y <= w_ball_y_next;
              r_vx     <= w_vx_next;
              r_vy     <= w_vy_next;
              if (w_hit)
                r_score <= w_score_inc;
            end
          end
        end
        MISS: begin
          if (w_tick) begin
            if (r_miss_cnt == c_MISS_LAST) begin
              r_miss_cnt <= '0;
              if (r_lives == 3'd0) begin
                r_state     <= OVER;
                r_game_over <= 1'b1;
              end else begin
                r_state  <= PLAY;
                r_ball_x <= c_SERVE_X;
                r_ball_y <= c_SERVE_Y;
                r_vx     <= vel_t'(c_SPEED0);
                r_vy     <= vel_t'(c_SPEED0);
              end
            end else begin
              r_miss_cnt <= r_miss_cnt + MW'(1);
            end
          end
        end
        OVER: begin
          if (start) begin
            r_state     <= IDLE;
            r_game_over <= 1'b0;
            r_lives     <= c_LIVES;
            r_score     <= 8'd0;
            r_paddle_y  <= c_PAD_Y0;
            r_ball_x    <= c_SERVE_X;
            r_ball_y    <= c_SERVE_Y;
            r_vx        <= vel_t'(c_SPEED0);
            r_vy        <= vel_t'(c_SPEED0);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  logic [10:0] w_pix_x, w_pix_y;
  logic        w_on_wall, w_on_pad, w_on_ball, w_ball_vis;

  assign w_pix_x    = {1'b0, pixel_x};
  assign w_pix_y    = {1'b0, pixel_y};
  assign w_ball_vis = (r_state == IDLE) || (r_state == PLAY);
  assign w_on_wall  = (w_pix_x >= c_WALL_L) && (w_pix_x < c_WALL_R);
  assign w_on_pad   = (w_pix_x >= c_PAD_L) && (w_pix_x <= c_PAD_R) &&
                      (w_pix_y >= w_pad) && (w_pix_y < w_pad + c_PH);
  assign w_on_ball  = w_ball_vis && (w_pix_x >= w_bx) && (w_pix_x < w_bx + c_BS) &&
                      (w_pix_y >= w_by) && (w_pix_y < w_by + c_BS);

  always_comb begin
    RGB = (r_state == OVER) ? c_RGB_OVER_BG : c_RGB_BG;
    if (!video_on)
      RGB = 12'h000;
    else if (w_on_wall)
      RGB = c_RGB_WALL;
    else if (w_on_pad)
      RGB = c_RGB_PADDLE;
    else if (w_on_ball)
      RGB = c_RGB_BALL;
  end

endmodule
`default_nettype wire
